rr_onoff_arbiter: RTL and testbench
===================================

# rr_onoff_arbiter

Round-robin arbiter that shares a single on/off resource between N requesters. Each requester asks for the resource with `req` and gives it back with `rel`, the same set/clear style as our two-state on/off controllers. The arbiter sequences ownership with a Moore state machine, enforces a one-cycle dead gap between owners, and can forcibly revoke a grant after a maximum hold time. It sits between the requesting blocks and the enable input of the shared on/off resource.

## Interface
- `N`, default 4: number of requesters, minimum 2.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership. 0 disables the timeout.
- `clk`  input  1: the single clock. All logic updates on the rising edge.
- `reset`  input  1: synchronous, active-low reset. `reset`=0 sampled at a rising edge resets the block.
- `req`  input  N: per-requester request, level-sensitive.
- `rel`  input  N: per-requester release. Only the bit for the current owner has any effect.
- `gnt`  output  N: one-hot grant, registered. All zero when nobody owns the resource.
- `busy`  output  1: registered. High exactly when `gnt` is nonzero.
- `owner`  output  max(1,$clog2(N)): index of the current owner, or of the last owner while idle or in the gap.
- `timeout`  output  1: registered one-cycle pulse, marking a grant that was revoked by the hold limit.

## Operation
- States: IDLE, GRANT and GAP.
- All outputs are registered and decoded from state and registers only (Moore). Inputs never reach outputs combinationally.
- Internal registers:
  - `ptr` (priority start index).
  - `hold_cnt`, wide enough to hold MAX_HOLD-1.
- Reset:
  - state=IDLE, `gnt`=0, `busy`=0, `owner`=0, `timeout`=0, `ptr`=0, `hold_cnt`=0.
  - Reset overrides every other condition, including mid-grant.
- IDLE and GAP use the same selection rule.
  - If `req` is nonzero, select the first set bit scanning `ptr`, `ptr`+1, ... mod N.
  - Next state is GRANT, with `owner` = the selected index, `gnt` = one-hot of it, and `hold_cnt` = 0.
  - Otherwise next state is IDLE.
  - GAP always lasts exactly one cycle.
- GRANT:
  - If `rel[owner]`=1: next state is GAP, `timeout`=0.
  - Else, if MAX_HOLD≠0 and `hold_cnt`==MAX_HOLD-1: next state is GAP, `timeout`=1.
  - Else stay in GRANT and increment `hold_cnt`.
  - On entering GAP: `ptr` = (`owner`+1) mod N, and `gnt`=0.
- `timeout` clears to 0 on the cycle after GAP.
- Boundary cases:
  - `rel` on a non-owner bit is ignored in every state.
  - `rel` set in IDLE or GAP is ignored.
  - `rel[owner]` and the hold limit in the same cycle count as a release: `timeout`=0.
  - The owner dropping `req` while still granted does not end the grant. Only `rel` or the timeout does.
  - A requester whose grant timed out can be re-granted after the gap if no other requester is pending. The rotation then wraps back to it.
  - `ptr` wraps from N-1 to 0.
  - With MAX_HOLD=0, `hold_cnt` may saturate or hold. It has no effect.

## Timing
- Request to grant: `req` sampled high at edge E in IDLE means `gnt` is high from edge E+1.
- Release to drop: `rel[owner]` sampled at edge R means `gnt` is low from edge R+1.
  - Total grant length is R-E cycles.
  - Minimum grant length is 1 cycle, when `rel` is high on the first GRANT cycle.
- Timeout: `gnt` stays high for exactly MAX_HOLD cycles. `timeout` is high for the single GAP cycle that follows.
- Back-to-back owners: exactly one cycle with `gnt`=0 between any two grants.
- Full rotation with N requesters continuously pending and releasing after one cycle takes 2N cycles.
- `busy` always equals |`gnt` in the same cycle.
- Reset: `reset`=0 sampled at edge X means all outputs take their reset values from X+1. `req` held through reset produces its first grant no earlier than X+2 after `reset` returns to 1.

## Test plan
1. Reset: hold `req`=4'b1111 with `reset`=0 for 3 cycles -> `gnt`=0, `busy`=0, `owner`=0, `timeout`=0 every cycle. After `reset`=1, `gnt`=4'b0001 one edge later.
2. Single requester: `req`=4'b0100 from cycle 0, then `rel`=4'b0100 for one cycle at cycle 4 -> `gnt`=4'b0100 during cycles 1–4, `owner`=2, `gnt`=0 from cycle 5, `timeout`=0 throughout.
3. Fairness: `req`=4'b1111 held, with each owner pulsing `rel` on its first grant cycle -> grant sequence 0,1,2,3,0 with one idle cycle between each grant (period 8 cycles).
4. Timeout (MAX_HOLD=8): `req`=4'b0010 held and `rel` never asserted -> `gnt[1]` high for exactly 8 cycles, `timeout`=1 for 1 cycle, then `gnt[1]` is re-granted. Repeat with `req`=4'b0110 -> the next grant goes to requester 2.
5. Foreign release and collision: requester 0 owns the resource, assert `rel`=4'b1000 -> no effect. Then assert `rel[0]` on the hold-limit cycle -> `gnt` drops and `timeout` stays 0.
6. Reset mid-grant: `reset`=0 on cycle 3 of a grant to requester 3 -> `gnt`=0 and `owner`=0 next edge. After release of reset with `req`=4'b1000, the grant restarts with `ptr`=0 scanning and reaches requester 3.

Source files
------------

// File: rtl/rr_onoff_arbiter_if.sv
// rr_onoff_arbiter_if: request/release inputs and registered grant outputs shared by the arbiter and its requesters.
interface rr_onoff_arbiter_if #(parameter int N = 4);
    localparam int OW = (N > 2) ? $clog2(N) : 1;
    logic [N-1:0]  req;
    logic [N-1:0]  rel;
    logic [N-1:0]  gnt;
    logic          busy;
    logic [OW-1:0] owner;
    logic          timeout;
    modport slave  (input req, rel, output gnt, busy, owner, timeout);
    modport master (output req, rel, input gnt, busy, owner, timeout);
endinterface

// File: rtl/rr_onoff_arbiter.sv
// rr_onoff_arbiter: round-robin Moore arbiter for one on/off resource, with a one-cycle dead gap between owners and an optional hold-time limit.
module rr_onoff_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input logic              clk,
    input logic              reset,
    rr_onoff_arbiter_if.slave bus
);
    localparam int OW = (N > 2) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        r_state, w_state;
    logic [N-1:0]  r_gnt, w_gnt;
    logic [OW-1:0] r_owner, w_owner, r_ptr, w_ptr, w_sel, w_owner_inc;
    logic [HW-1:0] r_hold, w_hold;
    logic          r_busy, r_timeout, w_timeout, w_found;

    // Scan from the highest offset down so the lowest offset past ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[(int'(r_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_sel   = OW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_owner_inc = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);

    always_comb begin
        w_state   = r_state;
        w_gnt     = r_gnt;
        w_owner   = r_owner;
        w_ptr     = r_ptr;
        w_hold    = r_hold;
        w_timeout = 1'b0;
        case (r_state)
            GRANT: begin
                if (bus.rel[r_owner]) begin
                    w_state = GAP;
                    w_gnt   = '0;
                    w_ptr   = w_owner_inc;
                end else if (MAX_HOLD != 0 && r_hold == HOLD_LAST) begin
                    w_state   = GAP;
                    w_gnt     = '0;
                    w_ptr     = w_owner_inc;
                    w_timeout = 1'b1;
                end else begin
                    w_hold = r_hold + HW'(1);
                end
            end
            default: begin
                w_state = w_found ? GRANT : IDLE;
                w_gnt   = w_found ? (N'(1) << w_sel) : '0;
                w_owner = w_found ? w_sel : r_owner;
                w_hold  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_gnt     <= w_gnt;
            r_busy    <= |w_gnt;
            r_owner   <= w_owner;
            r_ptr     <= w_ptr;
            r_hold    <= w_hold;
            r_timeout <= w_timeout;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = r_busy;
    assign bus.owner   = r_owner;
    assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_rr_onoff_arbiter.sv
// tb_rr_onoff_arbiter: directed and random stimulus scored against a behavioural ownership model through an expectation queue.
module tb_rr_onoff_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       timeout;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    rr_onoff_arbiter_if #(.N(N)) bus ();

    rr_onoff_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    int m_cur = 0, m_ptr = 0, m_len = 0;
    bit m_on = 0, m_to = 0;

    task automatic step(input logic [3:0] rq, input logic [3:0] rl, input logic rs);
        exp_t e;
        @(negedge clk);
        bus.req = rq;
        bus.rel = rl;
        reset   = rs;
        if (!rs) begin
            m_on = 0; m_to = 0; m_cur = 0; m_ptr = 0; m_len = 0;
        end else if (m_on) begin
            if (rl[m_cur]) begin
                m_on = 0; m_to = 0; m_ptr = (m_cur + 1) % N;
            end else if (MAX_HOLD != 0 && m_len == MAX_HOLD) begin
                m_on = 0; m_to = 1; m_ptr = (m_cur + 1) % N;
            end else begin
                m_len++;
            end
        end else begin
            m_to = 0;
            for (int k = 0; k < N; k++) begin
                if (rq[(m_ptr + k) % N]) begin
                    m_on = 1; m_cur = (m_ptr + k) % N; m_len = 1;
                    break;
                end
            end
        end
        e.gnt     = m_on ? 4'(1 << m_cur) : 4'b0;
        e.busy    = m_on;
        e.owner   = 2'(m_cur);
        e.timeout = m_to;
        q.push_back(e);
    endtask

    always begin
        exp_t e, a;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{gnt: bus.gnt, busy: bus.busy, owner: bus.owner, timeout: bus.timeout};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cyc%0d outputs: got gnt=%b busy=%b owner=%0d timeout=%b, want gnt=%b busy=%b owner=%0d timeout=%b",
                         cyc, a.gnt, a.busy, a.owner, a.timeout, e.gnt, e.busy, e.owner, e.timeout);
            end
        end
    end

    initial begin
        reset   = 1'b0;
        bus.req = '0;
        bus.rel = '0;
        repeat (3) step(4'hF, 4'h0, 1'b0);
        repeat (3) step(4'hF, 4'h0, 1'b1);
        step(4'h0, 4'h0, 1'b0);
        repeat (4) step(4'h4, 4'h0, 1'b1);
        step(4'h4, 4'h4, 1'b1);
        repeat (3) step(4'h0, 4'h0, 1'b1);
        repeat (17) step(4'hF, 4'hF, 1'b1);
        repeat (3) step(4'h0, 4'h0, 1'b1);
        repeat (22) step(4'h2, 4'h0, 1'b1);
        repeat (22) step(4'h6, 4'h0, 1'b1);
        repeat (3) step(4'h0, 4'h1, 1'b1);
        repeat (12) step(4'h1, (m_on && m_len == MAX_HOLD) ? 4'h1 : 4'h8, 1'b1);
        step(4'h0, 4'h0, 1'b0);
        repeat (3) step(4'h8, 4'h0, 1'b1);
        step(4'h8, 4'h0, 1'b0);
        repeat (5) step(4'h8, 4'h0, 1'b1);
        repeat (600) step(4'($urandom), ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0,
                          $urandom_range(0, 80) != 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
